// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM OBI arbiter: request/response payloads and
// the master-index width helper.
package sram_arb_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
    } obi_rsp_t;

    // A single master still needs a one-bit index.
    function automatic int id_width(int num_masters);
        return (num_masters > 1) ? $clog2(num_masters) : 1;
    endfunction

endpackage

// File: rtl/sram_obi_arbiter_if.sv
// Bus bundle around the arbiter: packed per-master request side plus the
// single SRAM-facing slave port. 'slave' is the arbiter's view.
interface sram_obi_arbiter_if #(
    parameter int NUM_MASTERS = 2
);
    logic [NUM_MASTERS-1:0]    m_req_i;
    logic [NUM_MASTERS-1:0]    m_gnt_o;
    logic [NUM_MASTERS*32-1:0] m_addr_i;
    logic [NUM_MASTERS-1:0]    m_we_i;
    logic [NUM_MASTERS*4-1:0]  m_be_i;
    logic [NUM_MASTERS*32-1:0] m_wdata_i;
    logic [NUM_MASTERS-1:0]    m_rvalid_o;
    logic [31:0]               m_rdata_o;
    logic                      s_req_o;
    logic                      s_gnt_i;
    logic [31:0]               s_addr_o;
    logic                      s_we_o;
    logic [3:0]                s_be_o;
    logic [31:0]               s_wdata_o;
    logic                      s_rvalid_i;
    logic [31:0]               s_rdata_i;
    logic                      rsp_err_o;

    modport slave (
        input  m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
        output m_gnt_o, m_rvalid_o, m_rdata_o,
        output s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o,
        input  s_gnt_i, s_rvalid_i, s_rdata_i,
        output rsp_err_o
    );

    modport master (
        output m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
        input  m_gnt_o, m_rvalid_o, m_rdata_o,
        input  s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o,
        output s_gnt_i, s_rvalid_i, s_rdata_i,
        input  rsp_err_o
    );

endinterface

// File: rtl/sram_obi_arbiter_fifo.sv
// In-order FIFO of granted master IDs used to route slave responses back.
// Push while full is accepted only together with a pop.
module obi_id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push, do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap explicitly so non-power-of-two depths stay correct.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_obi_arbiter.sv
// Round-robin arbiter sharing one SRAM OBI port between NUM_MASTERS
// requesters; responses are steered back in issue order via an ID FIFO.
module sram_obi_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_MASTERS     = 2,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ID_W            = id_width(NUM_MASTERS)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    sram_obi_arbiter_if.slave   bus
);
    logic [ID_W-1:0] rr_ptr, winner, fifo_head;
    logic            any_req, can_issue, handshake, pop;
    logic            fifo_full, fifo_empty, rsp_err;
    obi_req_t        win_req;
    obi_rsp_t        rsp;

    // Scan downward so the lowest offset from rr_ptr is written last and wins.
    always_comb begin
        winner  = '0;
        any_req = |bus.m_req_i;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (bus.m_req_i[(int'(rr_ptr) + k) % NUM_MASTERS]) begin
                winner = ID_W'((int'(rr_ptr) + k) % NUM_MASTERS);
            end
        end
    end

    always_comb begin
        win_req = '0;
        if (rst_ni && any_req) begin
            win_req.addr  = bus.m_addr_i[32*int'(winner) +: 32];
            win_req.we    = bus.m_we_i[winner];
            win_req.be    = bus.m_be_i[4*int'(winner) +: 4];
            win_req.wdata = bus.m_wdata_i[32*int'(winner) +: 32];
        end
    end

    // A response popping this cycle frees the slot for a new request.
    assign can_issue = !fifo_full || bus.s_rvalid_i;
    assign handshake = bus.s_req_o && bus.s_gnt_i;
    assign pop       = rst_ni && bus.s_rvalid_i && !fifo_empty;
    assign rsp.rdata = bus.s_rdata_i;

    assign bus.s_req_o   = rst_ni && any_req && can_issue;
    assign bus.s_addr_o  = win_req.addr;
    assign bus.s_we_o    = win_req.we;
    assign bus.s_be_o    = win_req.be;
    assign bus.s_wdata_o = win_req.wdata;
    assign bus.m_rdata_o = rsp.rdata;
    assign bus.rsp_err_o = rsp_err;

    always_comb begin
        bus.m_gnt_o    = '0;
        bus.m_rvalid_o = '0;
        if (handshake) begin
            bus.m_gnt_o[winner] = 1'b1;
        end
        if (pop) begin
            bus.m_rvalid_o[fifo_head] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr  <= '0;
            rsp_err <= 1'b0;
        end else begin
            if (handshake) begin
                rr_ptr <= (winner == ID_W'(NUM_MASTERS - 1)) ? '0 : winner + 1'b1;
            end
            if (bus.s_rvalid_i && fifo_empty) begin
                rsp_err <= 1'b1;
            end
        end
    end

    obi_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ID_W)
    ) u_id_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (handshake),
        .pop    (pop),
        .wdata  (winner),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .head   (fifo_head)
    );

endmodule

// File: doc/sram_obi_arbiter.md
Name: sram_obi_arbiter

Overview:
- Round-robin arbiter that shares one OBI slave port (the SRAM wrapper data port) between NUM_MASTERS OBI requesters, e.g. core LSU, DMA and debug.
- Muxes request fields onto the slave and records the granted master ID in a small in-order FIFO.
- Routes each slave rvalid/rdata back to the master that issued the request.
- Sits between the data-side interconnect mux and the SRAM wrapper d-port.

Parameters:
- NUM_MASTERS, 2: number of OBI requesters (2..4).
- MAX_OUTSTANDING, 2: depth of the response-routing ID FIFO (power of 2, ≥1).
- ID_W, $clog2(NUM_MASTERS) (min 1): width of the master index.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  reset, synchronous, active-low
- m_req_i  input  NUM_MASTERS  per-master request
- m_gnt_o  output  NUM_MASTERS  per-master grant
- m_addr_i  input  NUM_MASTERS*32  packed per-master address
- m_we_i  input  NUM_MASTERS  per-master write enable
- m_be_i  input  NUM_MASTERS*4  packed per-master byte enables
- m_wdata_i  input  NUM_MASTERS*32  packed per-master write data
- m_rvalid_o  output  NUM_MASTERS  per-master response valid
- m_rdata_o  output  32  read data, broadcast to all masters (qualified by m_rvalid_o)
- s_req_o  output  1  slave request
- s_gnt_i  input  1  slave grant
- s_addr_o  output  32  slave address
- s_we_o  output  1  slave write enable
- s_be_o  output  4  slave byte enables
- s_wdata_o  output  32  slave write data
- s_rvalid_i  input  1  slave response valid
- s_rdata_i  input  32  slave read data
- rsp_err_o  output  1  sticky flag: unsolicited slave response

Behaviour:
- Single clock clk_i. Reset rst_ni is synchronous, active-low.
- State:
  - rr_ptr (ID_W bits).
  - ID FIFO: MAX_OUTSTANDING entries, wr_ptr/rd_ptr/count.
  - rsp_err register.
- Reset values:
  - rr_ptr=0, FIFO empty (count=0), rsp_err_o=0.
  - While rst_ni=0: s_req_o, m_gnt_o and m_rvalid_o are forced 0. s_addr_o, s_we_o, s_be_o, s_wdata_o are 0. m_rdata_o=s_rdata_i.
- Arbitration is combinational, zero added latency:
  - winner = first index i with m_req_i[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_MASTERS.
- can_issue = (count<MAX_OUTSTANDING) || s_rvalid_i. A pop in the same cycle frees a slot.
- s_req_o = |m_req_i && can_issue.
- s_addr_o, s_we_o, s_be_o, s_wdata_o = fields of winner. All zero when no request.
- m_gnt_o[winner] = s_req_o && s_gnt_i. All other grants are 0.
- Handshake (s_req_o && s_gnt_i):
  - Push winner ID into the FIFO.
  - rr_ptr <= (winner+1) mod NUM_MASTERS.
  - Without a handshake, rr_ptr holds.
- Winner may change between cycles while s_gnt_i=0. A non-granted master must hold its request fields stable (OBI rule); the arbiter does not latch them.
- Response routing:
  - When s_rvalid_i=1 and count>0: m_rvalid_o[fifo_head]=1 in the same cycle, then pop.
  - m_rdata_o = s_rdata_i unconditionally.
  - Responses return strictly in issue order; writes also produce rvalid.
- Simultaneous push and pop: count unchanged, both pointers advance. Full plus pop plus push is legal.
- Unsolicited response (s_rvalid_i=1 with count=0): dropped, no m_rvalid_o, rsp_err_o <= 1. Stays 1 until reset.
- Pointer wrap: wr_ptr and rd_ptr wrap modulo MAX_OUTSTANDING. count ranges 0..MAX_OUTSTANDING.
- Reset mid-operation:
  - Outstanding IDs are discarded.
  - An s_rvalid_i arriving while rst_ni=0 is ignored and does not set rsp_err_o.
- With the SRAM wrapper (gnt=req, rvalid one cycle later), throughput is one access per cycle and the FIFO never exceeds 1 entry.

Decomposition:
- Package sram_arb_pkg: OBI request struct (addr, we, be, wdata), response struct (rdata), ID_W helper function.
- One sub-module: obi_id_fifo, a parameterized synchronous FIFO (DEPTH, WIDTH) with push/pop/full/empty/head. It uses the same clk_i/rst_ni.
- Arbiter top holds the round-robin logic, request mux and response demux.

Test Plan:
- Master 0 reads 0x8000_0010 at cycle 0 (slave returns 0xDEADBEEF at cycle 1) -> m_gnt_o=01 at cycle 0; m_rvalid_o=01, m_rdata_o=0xDEADBEEF at cycle 1; m_rvalid_o=00 at cycle 2.
- Both masters request continuously for 4 cycles from reset -> grants 0,1,0,1; rvalid to 0,1,0,1 one cycle later each; s_addr_o alternates between the two addresses.
- Slave model with 3-cycle rvalid latency, MAX_OUTSTANDING=2, master 0 requesting continuously -> two grants, then s_req_o=0 until the first rvalid. The third grant occurs in the same cycle as that rvalid (push+pop). count never exceeds 2.
- s_rvalid_i pulsed with empty FIFO -> m_rvalid_o=00, rsp_err_o=1 next cycle and held 1 for 10 cycles; clears only after rst_ni=0.
- Master 1 writes 0x1234_5678 with be=4'b0011 to 0x8000_0404 -> s_we_o=1, s_be_o=0011, s_wdata_o=0x1234_5678 same cycle; m_rvalid_o=10 next cycle.
- Grant to master 1 at cycle k, rst_ni=0 at cycle k+1 with s_rvalid_i=1 -> no m_rvalid_o, rsp_err_o=0. After release, rr_ptr=0: both masters requesting gives master 0 first.
